// File: rtl/s298_event_capture.sv
// Change-event capture for the s298 controller outputs: timestamps every
// change of STATE_IN and queues {state, timestamp} words in a small FIFO.
module s298_event_capture #(
   parameter int DEPTH = 4,
   parameter int TSW   = 8
) (
   input  logic                     CK,
   input  logic                     RN,
   input  logic                     EN,
   input  logic [5:0]               STATE_IN,
   output logic                     EVT_VALID,
   input  logic                     EVT_READY,
   output logic [6+TSW-1:0]         EVT_DATA,
   output logic                     OVF,
   input  logic                     CLR_OVF,
   output logic [$clog2(DEPTH):0]   COUNT
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 6 + TSW;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [TSW-1:0] ts;
   logic [5:0]     prev;
   logic           primed;
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;
   logic [AW:0]    count;
   logic           ovf_q;
   logic [EW-1:0]  mem [DEPTH];

   logic change;
   logic pop;
   logic full;
   logic accept;
   logic drop;

   // Pop decision uses the occupancy before this edge, so a push into an
   // empty FIFO can never be consumed on the same edge.
   always_comb begin
      change = EN && primed && (STATE_IN != prev);
      pop    = (count != '0) && EVT_READY;
      full   = (count == FULL_CNT);
      accept = change && (!full || pop);
      drop   = change && full && !pop;
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         ts     <= '0;
         prev   <= '0;
         primed <= 1'b0;
      end else if (EN) begin
         ts     <= ts + TSW'(1);
         prev   <= STATE_IN;
         primed <= 1'b1;
      end else begin
         primed <= 1'b0;
      end
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (accept)
            wptr <= wptr + AW'(1);
         if (pop)
            rptr <= rptr + AW'(1);
         case ({accept, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         // A drop on the same edge as a clear leaves the flag set.
         if (drop)
            ovf_q <= 1'b1;
         else if (CLR_OVF)
            ovf_q <= 1'b0;
      end
   end

   // Storage is data only; occupancy and pointers decide what is meaningful.
   always_ff @(posedge CK) begin
      if (accept)
         mem[wptr] <= {STATE_IN, ts};
   end

   assign EVT_VALID = (count != '0);
   assign EVT_DATA  = mem[rptr];
   assign OVF       = ovf_q;
   assign COUNT     = count;

endmodule

// File: doc/s298_event_capture.md
S298_EVENT_CAPTURE -- requirements
Module: s298_event_capture

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; power of two, 2..16.
REQ-002 Parameter TSW, default 8, timestamp width in bits, 4..16.
REQ-003 Port CK  in  1  single clock; all state updates on its rising edge.
REQ-004 Port RN  in  1  reset; asynchronous assertion, active-low.
REQ-005 Port EN  in  1  capture enable.
REQ-006 Port STATE_IN  in  6  controller outputs, bit order [5:0] = {G66, G67, G117, G118, G132, G133}.
REQ-007 Port EVT_VALID  out  1  FIFO head holds an event.
REQ-008 Port EVT_READY  in  1  consumer accepts the head.
REQ-009 Port EVT_DATA  out  6+TSW  head event: [6+TSW-1:TSW] = state, [TSW-1:0] = timestamp.
REQ-010 Port OVF  out  1  sticky flag: an event was dropped.
REQ-011 Port CLR_OVF  in  1  synchronous clear of OVF.
REQ-012 Port COUNT  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 Timestamp counter TS (TSW bits) SHALL increment by 1 on each edge with EN=1, hold when EN=0, and wrap from 2^TSW-1 to 0.
REQ-014 The block SHALL hold PREV (6 bits) and PRIMED (1 bit); on each edge with EN=1, PREV <= STATE_IN and PRIMED <= 1.
REQ-015 An edge with EN=0 SHALL clear PRIMED and leave PREV unchanged.
REQ-016 A change SHALL be detected at an edge with EN=1, PRIMED=1 and STATE_IN != PREV.
REQ-017 The first edge with EN=1 after reset or after EN=0 SHALL only load PREV and SHALL NOT generate an event.
REQ-018 On a detected change, the event word {STATE_IN, TS} SHALL be pushed, using the pre-increment value of TS at that edge.
REQ-019 Latency: a pushed event SHALL be visible at the FIFO tail one edge after the change is sampled; if the FIFO was empty, EVT_VALID SHALL be 1 immediately after that edge.
REQ-020 An empty FIFO SHALL NOT bypass input data to the output; EVT_DATA SHALL always come from FIFO storage.
REQ-021 Pop SHALL occur at an edge where EVT_VALID=1 and EVT_READY=1; EVT_READY with an empty FIFO SHALL have no effect.
REQ-022 EVT_VALID SHALL equal (COUNT != 0); EVT_DATA SHALL be stable while EVT_VALID=1 and EVT_READY=0.
REQ-023 Push and pop at the same edge SHALL both take effect, and COUNT SHALL be unchanged.
REQ-024 With the FIFO full, a push SHALL be accepted only if a pop occurs at the same edge; otherwise the event is dropped and OVF <= 1.
REQ-025 A push with the FIFO empty and EVT_READY=1 SHALL NOT pop; the pop applies from the next edge.
REQ-026 OVF SHALL clear on an edge with CLR_OVF=1; if a drop occurs at the same edge, the set SHALL win.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; events SHALL leave in strict FIFO order.
REQ-028 COUNT SHALL range 0..DEPTH and never exceed DEPTH.

Reset
REQ-029 RN=0 SHALL immediately force TS=0, PREV=0, PRIMED=0, COUNT=0, EVT_VALID=0, OVF=0, and pointers=0.
REQ-030 EVT_DATA value is don't-care while EVT_VALID=0.
REQ-031 Reset asserted mid-operation SHALL discard all queued events, without requiring a clock edge.
REQ-032 Deassertion of RN SHALL be synchronised to CK by the integrator; the first active edge SHALL behave as in REQ-017.

Verification
REQ-033 Reset, then EN=1 with STATE_IN=6'h00 constant for 10 cycles -> EVT_VALID stays 0 and TS=10.
REQ-034 EN=1, STATE_IN changes from 6'h00 to 6'h21 when TS=5, EVT_READY=1 -> next cycle EVT_VALID=1 with EVT_DATA={6'h21, 8'h05}, popped on the following edge, COUNT returns to 0.
REQ-035 EVT_READY=0, 5 distinct changes with DEPTH=4 -> COUNT=4, OVF=1, and the first 4 events drain in order; CLR_OVF then clears OVF.
REQ-036 FIFO full, change coinciding with a pop -> no drop, OVF stays 0, COUNT stays 4.
REQ-037 TS at 8'hFF, change sampled -> timestamp 8'hFF stored and TS wraps to 0; EN=0 for 3 cycles, then a change on the first re-enabled edge -> no event, and TS held during EN=0.
REQ-038 RN pulsed low with COUNT=3 -> EVT_VALID and COUNT drop to 0 asynchronously, and OVF=0.
